// File: rtl/rmt_pkt_classifier_pkg.sv
// Shared constants, header offsets and enums for the ingress packet classifier.
package rmt_pkg;

  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  localparam logic [7:0]  IP_UDP        = 8'h11;
  localparam int          OFF_ETHERTYPE = 12;
  localparam int          OFF_PROTO     = 23;
  localparam int          OFF_DPORT     = 36;
  // The last header byte we parse; a first beat without it is a runt.
  localparam int          RUNT_KEEP_BIT = OFF_DPORT + 1;

  typedef enum logic [1:0] {CLS_DATA, CLS_CFG, CLS_DROP} cls_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FWD_DATA, ST_FWD_CFG, ST_DROP} state_e;

  function automatic logic [7:0] get_byte(input logic [511:0] d, input int idx);
    return d[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/rmt_pkt_classifier_if.sv
// AXI-Stream bundle used for the classifier's input and both outputs.
interface rmt_pkt_classifier_if #(
  parameter int DW = 512,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_pkt_classifier_axis_out_reg.sv
// Single-entry AXI-Stream output register; drains and reloads in one cycle.
module axis_out_reg #(
  parameter int DW = 512,
  parameter int UW = 128
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                load_i,
  input  logic [DW-1:0]       tdata_i,
  input  logic [DW/8-1:0]     tkeep_i,
  input  logic [UW-1:0]       tuser_i,
  input  logic                tlast_i,
  output logic                can_accept_o,
  rmt_pkt_classifier_if.master m_axis
);

  logic            tvalid_q;
  logic [DW-1:0]   tdata_q;
  logic [DW/8-1:0] tkeep_q;
  logic [UW-1:0]   tuser_q;
  logic            tlast_q;

  assign can_accept_o = !tvalid_q || m_axis.tready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load_i) begin
      tvalid_q <= 1'b1;
      tdata_q  <= tdata_i;
      tkeep_q  <= tkeep_i;
      tuser_q  <= tuser_i;
      tlast_q  <= tlast_i;
    end else if (m_axis.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;

endmodule

// File: rtl/rmt_pkt_classifier.sv
// Ingress classifier: routes each packet to the RMT data path or the config
// loader based on its first beat, drops runts/disabled config, counts packets.
module rmt_pkt_classifier
  import rmt_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CFG_UDP_PORT         = 16'hf1f2,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  rmt_pkt_classifier_if.slave   s_axis,
  rmt_pkt_classifier_if.master  m_data_axis,
  rmt_pkt_classifier_if.master  m_cfg_axis,
  input  logic                  cfg_en,
  output logic [CNT_WIDTH-1:0]  cnt_data,
  output logic [CNT_WIDTH-1:0]  cnt_cfg,
  output logic [CNT_WIDTH-1:0]  cnt_drop
);

  state_e state_q, state_d;
  cls_e   hdr_cls, route;
  logic   data_can, cfg_can, s_ready, accept, load_data, load_cfg;
  logic [15:0] ethertype, dport;
  logic [7:0]  proto;
  logic [CNT_WIDTH-1:0] cnt_data_q, cnt_cfg_q, cnt_drop_q;

  assign ethertype = {get_byte(s_axis.tdata, OFF_ETHERTYPE), get_byte(s_axis.tdata, OFF_ETHERTYPE + 1)};
  assign proto     = get_byte(s_axis.tdata, OFF_PROTO);
  assign dport     = {get_byte(s_axis.tdata, OFF_DPORT), get_byte(s_axis.tdata, OFF_DPORT + 1)};

  always_comb begin
    hdr_cls = CLS_DATA;
    if (!s_axis.tkeep[RUNT_KEEP_BIT])
      hdr_cls = CLS_DROP;
    else if (ethertype == ETH_IPV4 && proto == IP_UDP && dport == CFG_UDP_PORT)
      hdr_cls = cfg_en ? CLS_CFG : CLS_DROP;
  end

  // IDLE readiness must not depend on the undecoded header, so both outputs must be free.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    route   = CLS_DROP;
    unique case (state_q)
      ST_IDLE:     begin s_ready = data_can && cfg_can; route = hdr_cls;  end
      ST_FWD_DATA: begin s_ready = data_can;            route = CLS_DATA; end
      ST_FWD_CFG:  begin s_ready = cfg_can;             route = CLS_CFG;  end
      ST_DROP:     begin s_ready = 1'b1;                route = CLS_DROP; end
      default:     ;
    endcase
    s_ready = s_ready && aresetn;
    accept  = s_axis.tvalid && s_ready;
    if (accept) begin
      if (s_axis.tlast) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        unique case (hdr_cls)
          CLS_DATA: state_d = ST_FWD_DATA;
          CLS_CFG:  state_d = ST_FWD_CFG;
          default:  state_d = ST_DROP;
        endcase
      end
    end
  end

  assign load_data     = accept && (route == CLS_DATA);
  assign load_cfg      = accept && (route == CLS_CFG);
  assign s_axis.tready = s_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_data_q <= '0;
      cnt_cfg_q  <= '0;
      cnt_drop_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && s_axis.tlast) begin
        unique case (route)
          CLS_DATA: cnt_data_q <= cnt_data_q + CNT_WIDTH'(1);
          CLS_CFG:  cnt_cfg_q  <= cnt_cfg_q + CNT_WIDTH'(1);
          default:  cnt_drop_q <= cnt_drop_q + CNT_WIDTH'(1);
        endcase
      end
    end
  end

  assign cnt_data = cnt_data_q;
  assign cnt_cfg  = cnt_cfg_q;
  assign cnt_drop = cnt_drop_q;

  axis_out_reg #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) u_data_reg (
    .clk          (clk),
    .aresetn      (aresetn),
    .load_i       (load_data),
    .tdata_i      (s_axis.tdata),
    .tkeep_i      (s_axis.tkeep),
    .tuser_i      (s_axis.tuser),
    .tlast_i      (s_axis.tlast),
    .can_accept_o (data_can),
    .m_axis       (m_data_axis)
  );

  axis_out_reg #(.DW(C_S_AXIS_DATA_WIDTH), .UW(C_S_AXIS_TUSER_WIDTH)) u_cfg_reg (
    .clk          (clk),
    .aresetn      (aresetn),
    .load_i       (load_cfg),
    .tdata_i      (s_axis.tdata),
    .tkeep_i      (s_axis.tkeep),
    .tuser_i      (s_axis.tuser),
    .tlast_i      (s_axis.tlast),
    .can_accept_o (cfg_can),
    .m_axis       (m_cfg_axis)
  );

endmodule

// File: tb/tb_rmt_pkt_classifier.sv
// Randomized bench for rmt_pkt_classifier with a packet-level reference model.
module tb_rmt_pkt_classifier;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_en = 1'b0;
  logic [31:0] cnt_data, cnt_cfg, cnt_drop;

  rmt_pkt_classifier_if s_axis ();
  rmt_pkt_classifier_if m_data_axis ();
  rmt_pkt_classifier_if m_cfg_axis ();

  rmt_pkt_classifier dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .s_axis      (s_axis),
    .m_data_axis (m_data_axis),
    .m_cfg_axis  (m_cfg_axis),
    .cfg_en      (cfg_en),
    .cnt_data    (cnt_data),
    .cnt_cfg     (cnt_cfg),
    .cnt_drop    (cnt_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t       exp_data[$];
  beat_t       exp_cfg[$];
  logic        pat[$];
  logic [31:0] m_cnt_data = 0, m_cnt_cfg = 0, m_cnt_drop = 0;
  bit          rand_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(string tag, logic [704:0] got, logic [704:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0 = data, 1 = config, 2 = drop
  function automatic int ref_class(logic [511:0] d, logic [63:0] k, bit en);
    logic [15:0] et = {d[12*8 +: 8], d[13*8 +: 8]};
    logic [7:0]  pr = d[23*8 +: 8];
    logic [15:0] dp = {d[36*8 +: 8], d[37*8 +: 8]};
    if (!k[37]) return 2;
    if (et == 16'h0800 && pr == 8'h11 && dp == 16'hf1f2) return en ? 1 : 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (pat.size() != 0) m_data_axis.tready = pat.pop_front();
    else m_data_axis.tready = rand_ready ? 1'($urandom) : 1'b1;
    m_cfg_axis.tready = rand_ready ? 1'($urandom) : 1'b1;
  end

  beat_t dcur, dheld, ccur, cheld;
  bit    dstall = 1'b0, cstall = 1'b0;

  always begin
    @(negedge clk);
    #2;
    dcur = {m_data_axis.tdata, m_data_axis.tkeep, m_data_axis.tuser, m_data_axis.tlast};
    if (!aresetn) dstall = 1'b0;
    else begin
      if (dstall) check("data_hold", dcur, dheld);
      if (m_data_axis.tvalid && m_data_axis.tready) begin
        if (exp_data.size() == 0) check("data_unexpected", 1, 0);
        else check("data_beat", dcur, exp_data.pop_front());
      end
      dstall = m_data_axis.tvalid && !m_data_axis.tready;
      dheld  = dcur;
    end
  end

  always begin
    @(negedge clk);
    #2;
    ccur = {m_cfg_axis.tdata, m_cfg_axis.tkeep, m_cfg_axis.tuser, m_cfg_axis.tlast};
    if (!aresetn) cstall = 1'b0;
    else begin
      if (cstall) check("cfg_hold", ccur, cheld);
      if (m_cfg_axis.tvalid && m_cfg_axis.tready) begin
        if (exp_cfg.size() == 0) check("cfg_unexpected", 1, 0);
        else check("cfg_beat", ccur, exp_cfg.pop_front());
      end
      cstall = m_cfg_axis.tvalid && !m_cfg_axis.tready;
      cheld  = ccur;
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(beat_t b, int cls, inout int stalls);
    int n = 0;
    bit ok = 1'b0;
    {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast} = b;
    s_axis.tvalid = 1'b1;
    while (!ok) begin
      #1;
      if (s_axis.tready) begin
        ok = 1'b1;
        if (cls == 0) exp_data.push_back(b);
        else if (cls == 1) exp_cfg.push_back(b);
        if (b.l) begin
          if (cls == 0) m_cnt_data++;
          else if (cls == 1) m_cnt_cfg++;
          else m_cnt_drop++;
        end
      end else begin
        stalls++;
        n++;
      end
      @(negedge clk);
      if (!ok && n > 500) begin
        check("s_ready_timeout", 0, 1);
        ok = 1'b1;
      end
    end
    if (cls == 0 && n <= 500) check("data_latency", m_data_axis.tvalid, 1);
    if (cls == 1 && n <= 500) check("cfg_latency", m_cfg_axis.tvalid, 1);
    s_axis.tvalid = 1'b0;
  endtask

  // kind: 0 random, 1 config header, 2 runt, 3 UDP to another port
  task automatic send_pkt(int kind, int nb, int nsend, bit en, output int stalls);
    beat_t b;
    int    cls = 0;
    stalls = 0;
    cfg_en = en;
    for (int i = 0; i < nsend; i++) begin
      for (int w = 0; w < 16; w++) b.d[w*32 +: 32] = $urandom;
      for (int w = 0; w < 4; w++) b.u[w*32 +: 32] = $urandom;
      b.k = (i == nb - 1 && nb > 1) ? {$urandom, $urandom} : '1;
      b.l = (i == nb - 1);
      if (i == 0) begin
        if (kind == 1 || kind == 3) begin
          b.d[12*8 +: 8] = 8'h08;
          b.d[13*8 +: 8] = 8'h00;
          b.d[23*8 +: 8] = 8'h11;
          b.d[36*8 +: 8] = (kind == 1) ? 8'hf1 : 8'h10;
          b.d[37*8 +: 8] = (kind == 1) ? 8'hf2 : 8'h00;
        end
        if (kind == 2) b.k = 64'h000000000000001f;
        cls = ref_class(b.d, b.k, en);
      end
      send_beat(b, cls, stalls);
      if (i == 0) cfg_en = 1'($urandom);
    end
  endtask

  task automatic drain_and_count();
    int n = 0;
    while ((exp_data.size() != 0 || exp_cfg.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_data", exp_data.size(), 0);
    check("drain_cfg", exp_cfg.size(), 0);
    check("cnt_data", cnt_data, m_cnt_data);
    check("cnt_cfg", cnt_cfg, m_cnt_cfg);
    check("cnt_drop", cnt_drop, m_cnt_drop);
  endtask

  initial begin
    int st;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tuser  = '0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_axis.tready, 0);
    check("rst_data_valid", m_data_axis.tvalid, 0);
    check("rst_cfg_valid", m_cfg_axis.tvalid, 0);
    check("rst_cnt", {cnt_data, cnt_cfg, cnt_drop}, 0);
    aresetn = 1'b1;
    @(negedge clk);

    send_pkt(1, 2, 2, 1'b1, st);
    drain_and_count();
    $display("config packet: cnt_cfg=%0d", cnt_cfg);

    send_pkt(3, 1, 1, 1'b1, st);
    drain_and_count();
    $display("data packet: cnt_data=%0d", cnt_data);

    send_pkt(1, 2, 2, 1'b0, st);
    check("cfg_off_no_stall", st, 0);
    drain_and_count();
    $display("config disabled: cnt_drop=%0d", cnt_drop);

    send_pkt(2, 1, 1, 1'b1, st);
    drain_and_count();
    $display("runt: cnt_drop=%0d", cnt_drop);

    pat.push_back(1'b1); pat.push_back(1'b0); pat.push_back(1'b0); pat.push_back(1'b1);
    send_pkt(3, 3, 3, 1'b1, st);
    drain_and_count();
    $display("backpressure: stalls=%0d", st);

    send_pkt(1, 3, 1, 1'b1, st);
    repeat (2) @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    m_cnt_data = 0; m_cnt_cfg = 0; m_cnt_drop = 0;
    check("midrst_data_valid", m_data_axis.tvalid, 0);
    check("midrst_cfg_valid", m_cfg_axis.tvalid, 0);
    check("midrst_cnt", {cnt_data, cnt_cfg, cnt_drop}, 0);
    check("midrst_q", exp_cfg.size() + exp_data.size(), 0);
    aresetn = 1'b1;
    @(negedge clk);
    send_pkt(3, 2, 2, 1'b1, st);
    drain_and_count();
    $display("reset mid-packet: cnt_data=%0d", cnt_data);

    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int kind = $urandom_range(0, 3);
      int nb   = $urandom_range(1, 4);
      send_pkt(kind, nb, nb, 1'($urandom), st);
      $display("pkt %0d kind=%0d beats=%0d stalls=%0d", p, kind, nb, st);
    end
    drain_and_count();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
